// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, key event payload and sequencer state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    // Keyboard status/ack bytes that never form part of a key event.
    function automatic logic is_sys_byte(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO; head word is always visible on o_rdata.
module ps2_event_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot the write lands in, so a full FIFO still accepts.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Assembles PS/2 scan-code bytes into make/break key events (optionally E0-extended)
// and queues them in a small show-ahead event FIFO.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_err,
    input  logic                          ev_pop,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    output logic                          seq_abort
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_seq_abort;
    logic             r_overflow;
    logic             w_drop;
    logic             w_timeout;
    logic             w_push;
    logic             w_abort;
    logic             w_full;
    logic             w_empty;
    key_event_t       w_push_ev;
    key_event_t       w_head;

    // Byte decode: a valid byte on the timeout cycle takes priority over the abort.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        w_push_ev   = '{ext: 1'b0, brk: 1'b0, code: rx_data};
        w_drop      = rx_valid && (rx_err || is_sys_byte(rx_data));
        w_timeout   = (r_state != S_IDLE) && (r_cnt == CNT_LAST) && !rx_valid;

        if (w_drop) begin
            w_state_nxt = S_IDLE;
            w_abort     = (r_state != S_IDLE);
        end else if (rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        w_state_nxt = S_EXT;
                    end else if (rx_data == SC_BRK) begin
                        w_state_nxt = S_BRK;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == SC_BRK) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (rx_data != SC_EXT) begin
                        w_push        = 1'b1;
                        w_push_ev.ext = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (rx_data == SC_EXT) begin
                        w_abort     = 1'b1;
                        w_state_nxt = S_EXT;
                    end else if (rx_data != SC_BRK) begin
                        w_push        = 1'b1;
                        w_push_ev.brk = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    w_state_nxt = S_IDLE;
                    if (rx_data == SC_EXT || rx_data == SC_BRK) begin
                        w_abort = 1'b1;
                    end else begin
                        w_push        = 1'b1;
                        w_push_ev.ext = 1'b1;
                        w_push_ev.brk = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_abort     = 1'b1;
        end
    end

    // Sequencer state, inter-byte timeout counter and status flags.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_seq_abort <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_seq_abort <= w_abort;
            if (rx_valid || w_timeout || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_push && w_full && !ev_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ps2_event_fifo #(
        .WIDTH ($bits(key_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_wdata (w_push_ev),
        .i_pop   (ev_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (ev_count)
    );

    assign ev_valid  = !w_empty;
    assign ev_code   = w_head.code;
    assign ev_ext    = w_head.ext;
    assign ev_break  = w_head.brk;
    assign overflow  = r_overflow;
    assign seq_abort = r_seq_abort;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed + randomized bench for ps2_key_sequencer against a prefix-flag / queue reference model.
module tb_ps2_key_sequencer;

    localparam int TO    = 20;
    localparam int DEPTH = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       ev_pop;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [2:0] ev_count;
    logic       overflow;
    logic       seq_abort;

    ps2_key_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .ev_pop    (ev_pop),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .ev_count  (ev_count),
        .overflow  (overflow),
        .seq_abort (seq_abort)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model: pending-prefix flags, time of last byte, queue of {ext,brk,code}.
    bit         m_ext;
    bit         m_brk;
    bit         m_ovf;
    bit         m_abort;
    int         last_byte;
    int         cyc;
    logic [9:0] q[$];
    int         n_vec;
    int         n_err;
    logic [7:0] sys_list [9] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_sys(input logic [7:0] b);
        for (int i = 0; i < 9; i++) begin
            if (sys_list[i] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_outputs();
        chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
        chk("ev_count", 32'(ev_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("seq_abort", 32'(seq_abort), 32'(m_abort));
        if (q.size() != 0) chk("head", 32'({ev_ext, ev_break, ev_code}), 32'(q[0]));
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_abort = 0; q.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic e, input logic p);
        logic [9:0] ev;
        bit push, ab;
        push = 0; ab = 0; ev = '0;
        if (v) begin
            last_byte = cyc;
            if (e || is_sys(d)) begin
                ab = m_ext || m_brk; m_ext = 0; m_brk = 0;
            end else if (d == 8'hE0) begin
                if (m_ext && m_brk) begin ab = 1; m_ext = 0; m_brk = 0; end
                else if (m_brk) begin ab = 1; m_brk = 0; m_ext = 1; end
                else m_ext = 1;
            end else if (d == 8'hF0) begin
                if (m_ext && m_brk) begin ab = 1; m_ext = 0; m_brk = 0; end
                else m_brk = 1;
            end else begin
                ev = {m_ext, m_brk, d}; push = 1; m_ext = 0; m_brk = 0;
            end
        end else if ((m_ext || m_brk) && (cyc - last_byte == TO)) begin
            ab = 1; m_ext = 0; m_brk = 0;
        end
        if (p && q.size() > 0) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1;
        end
        m_abort = ab;
    endtask

    // One clock cycle: check the registered outputs, then apply this cycle's inputs.
    task automatic tick(input logic v, input logic [7:0] d, input logic e, input logic p);
        @(negedge CLOCK_50);
        check_outputs();
        rx_valid = v; rx_data = d; rx_err = e; ev_pop = p;
        model_step(v, d, e, p);
        cyc++;
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic p);
        repeat (n) tick(1'b0, 8'h00, 1'b0, p);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; last_byte = 0;
        model_reset();
        reset = 1'b1; rx_valid = 0; rx_data = 8'h00; rx_err = 0; ev_pop = 0;
        #1;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_count", 32'(ev_count), 32'd0);
        chk("rst_head", 32'({ev_ext, ev_break, ev_code}), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_abort", 32'(seq_abort), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Single make code, then pop.
        send(8'h1C); idle(1, 1'b0); idle(1, 1'b1); idle(1, 1'b0);
        // Break, then extended break.
        send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h75);
        idle(4, 1'b1);
        // Timeout after E0, then a plain code.
        send(8'hE0); idle(TO, 1'b0); idle(2, 1'b0); send(8'h75); idle(1, 1'b1);
        // Byte on the exact timeout cycle wins.
        send(8'hE0); idle(TO - 1, 1'b0); send(8'h75); idle(2, 1'b1);
        // Errored byte, system byte aborts, ack byte in idle.
        tick(1'b1, 8'hF0, 1'b1, 1'b0); send(8'h1C); send(8'hF0); send(8'hAA); send(8'hFA);
        idle(3, 1'b1);
        // BRK->E0 and EXT_BRK->E0 aborts.
        send(8'hF0); send(8'hE0); send(8'hF0); send(8'hE0); idle(2, 1'b0);
        // Fill, push+pop at full, then overflow.
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        tick(1'b1, 8'h55, 1'b0, 1'b1);
        send(8'h66); idle(1, 1'b0);
        idle(6, 1'b1);

        // Asynchronous reset mid-sequence with events queued.
        send(8'h11); send(8'h22); send(8'h33); send(8'hE0);
        @(negedge CLOCK_50);
        check_outputs();
        rx_valid = 0; ev_pop = 0;
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(ev_valid), 32'd0);
        chk("arst_count", 32'(ev_count), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(negedge CLOCK_50);
        reset = 1'b0;
        send(8'h1C); idle(1, 1'b0); idle(1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                idle(TO - 2 + int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0);
            end else begin
                int r;
                logic [7:0] d;
                r = int'($urandom_range(0, 99));
                if (r < 15)      d = 8'hE0;
                else if (r < 30) d = 8'hF0;
                else if (r < 38) d = sys_list[$urandom_range(0, 8)];
                else             d = 8'($urandom_range(0, 255));
                tick($urandom_range(0, 3) == 0, d, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end
        idle(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
